// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter sequencer with a RUN/HALTED FSM, jumps,
// conditional jumps on the upstream zero flag, and an optional return stack.
// Optional feature macro: CALL_STACK_EN. When it is defined, the return stack
// and call/ret behaviour are built. When it is not defined, call and ret act
// as plain increments and stack_err is tied low.
module pc_sequencer #(
    parameter int PC_WIDTH    = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                pc_en,
    input  logic                jmp,
    input  logic                jmpz,
    input  logic                zero_flag,
    input  logic [PC_WIDTH-1:0] target,
    input  logic                call,
    input  logic                ret,
    input  logic                halt,
    input  logic                resume,
    output logic [PC_WIDTH-1:0] pc,
    output logic                halted,
    output logic                stack_err
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] pc_inc;

    // Natural wrap from all-ones to zero comes from the fixed width.
    assign pc_inc = pc_q + PC_WIDTH'(1);

`ifdef CALL_STACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic [SP_W-1:0]     sp_q, sp_d;
    logic                err_q, err_d;
    logic                push;
    logic                stack_full;
    logic                stack_empty;
    logic [IDX_W-1:0]    push_idx;
    logic [IDX_W-1:0]    top_idx;

    // sp_q counts occupied entries; push writes at sp_q, pop reads sp_q-1.
    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);
    assign push_idx    = IDX_W'(sp_q);
    assign top_idx     = IDX_W'(sp_q - SP_W'(1));
`else
    // Depth only matters when the stack is built.
    localparam int unused_stack_depth = STACK_DEPTH;
`endif

    // Next-state decode: one action per enabled RUN cycle, in priority order.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
`ifdef CALL_STACK_EN
        sp_d    = sp_q;
        err_d   = err_q;
        push    = 1'b0;
`endif
        case (state_q)
            ST_RUN: begin
                if (pc_en) begin
                    if (halt) begin
                        state_d = ST_HALTED;
`ifdef CALL_STACK_EN
                    end else if (ret) begin
                        if (!stack_empty) begin
                            pc_d = stack_mem[top_idx];
                            sp_d = sp_q - SP_W'(1);
                        end else begin
                            pc_d  = pc_inc;
                            err_d = 1'b1;
                        end
                    end else if (call) begin
                        if (!stack_full) begin
                            push = 1'b1;
                            pc_d = target;
                            sp_d = sp_q + SP_W'(1);
                        end else begin
                            pc_d  = pc_inc;
                            err_d = 1'b1;
                        end
`else
                    end else if (ret || call) begin
                        pc_d = pc_inc;
`endif
                    end else if (jmp || (jmpz && zero_flag)) begin
                        pc_d = target;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Control state registers, cleared asynchronously by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
`ifdef CALL_STACK_EN
            sp_q    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
`ifdef CALL_STACK_EN
            sp_q    <= sp_d;
            err_q   <= err_d;
`endif
        end
    end

`ifdef CALL_STACK_EN
    // Return-address storage; contents need no reset, only the count does.
    always_ff @(posedge clock) begin
        if (push) begin
            stack_mem[push_idx] <= pc_inc;
        end
    end

    assign stack_err = err_q;
`else
    assign stack_err = 1'b0;
`endif

    assign pc     = pc_q;
    assign halted = (state_q == ST_HALTED);

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_WIDTH, default 8, width of program counter and jump target.
REQ-002 Parameter STACK_DEPTH, default 4, number of return-address entries, at least 1.
REQ-003 clock  input  1  Rising-edge clock; the block has one clock.
REQ-004 reset  input  1  Asynchronous, active-high reset.
REQ-005 pc_en  input  1  Advance enable; when low, all state holds.
REQ-006 jmp  input  1  Unconditional jump request.
REQ-007 jmpz  input  1  Conditional jump request, taken when zero_flag is high.
REQ-008 zero_flag  input  1  Registered ALU zero flag from the upstream flag register.
REQ-009 target  input  PC_WIDTH  Jump or call destination address.
REQ-010 call  input  1  Push return address and jump to target.
REQ-011 ret  input  1  Pop return address into PC.
REQ-012 halt  input  1  Enter HALTED state.
REQ-013 resume  input  1  Leave HALTED state.
REQ-014 pc  output  PC_WIDTH  Current program counter (registered).
REQ-015 halted  output  1  High while in HALTED state (registered).
REQ-016 stack_err  output  1  Sticky overflow or underflow indicator (registered).

Function
REQ-017 The FSM SHALL have two states, RUN and HALTED, with transitions taken on the rising clock edge.
REQ-018 In RUN with pc_en high, exactly one action SHALL occur per cycle, in this priority: halt > ret > call > jmp > jmpz-taken > increment.
REQ-019 A halt SHALL move the FSM to HALTED with the PC unchanged.
REQ-020 A ret with a non-empty stack SHALL load pc from the top entry and pop it.
REQ-021 A call with a non-full stack SHALL push pc+1 (modulo 2^PC_WIDTH) and load pc with target.
REQ-022 A jmp, or a jmpz with zero_flag high, SHALL load pc with target; a jmpz with zero_flag low SHALL increment pc.
REQ-023 An increment SHALL wrap from 2^PC_WIDTH-1 to 0.
REQ-024 A call on a full stack SHALL leave the stack unchanged, increment pc, and set stack_err.
REQ-025 A ret on an empty stack SHALL increment pc and set stack_err.
REQ-026 stack_err SHALL remain set until reset.
REQ-027 In RUN with pc_en low, pc, stack and state SHALL hold and all requests SHALL be ignored.
REQ-028 In HALTED, all inputs except resume SHALL be ignored, regardless of pc_en.
REQ-029 In HALTED, resume SHALL return the FSM to RUN on the next edge with pc unchanged; the first advance SHALL occur in the following cycle.
REQ-030 zero_flag SHALL be sampled in the same cycle as jmpz, with no additional internal registering.
REQ-031 Every change to pc SHALL appear one cycle after the request edge.

Reset
REQ-032 While reset is high, the block SHALL force pc=0, state=RUN, halted=0, stack_err=0, and the stack empty, asynchronously.
REQ-033 A reset asserted mid-operation, including in HALTED or with a full stack, SHALL discard all state with no pending action completed.
REQ-034 Stack entry contents are don't-care after reset; only the stack occupancy count is reset.

Configuration
REQ-035 The macro CALL_STACK_EN SHALL include the return stack and the call/ret behaviour of REQ-020, REQ-021, REQ-024 and REQ-025.
REQ-036 Without CALL_STACK_EN, the call and ret ports SHALL remain present and be treated as increment, stack_err SHALL be tied to 0, and no stack storage SHALL be synthesized.

Verification
REQ-037 The bench SHALL cover: reset, then pc_en=1 for 300 cycles -> pc counts 0..255, wraps to 0, and reads 44 at cycle 300.
REQ-038 The bench SHALL cover: pc=5, jmpz=1, target=0x40, zero_flag=0 -> pc=6; next cycle jmpz with zero_flag=1 -> pc=0x40.
REQ-039 The bench SHALL cover: pc=0x10, halt and jmp asserted together -> halted=1, pc=0x10; jmp held 5 cycles -> pc=0x10; resume -> halted=0, then pc=0x11 after one advance.
REQ-040 The bench SHALL cover (CALL_STACK_EN): 4 nested calls from pc=1,0x21,0x31,0x41 with targets 0x20,0x30,0x40,0x50 -> 4 rets return to 0x42,0x32,0x22,0x02; a 5th ret -> stack_err=1, pc increments.
REQ-041 The bench SHALL cover (CALL_STACK_EN): 5 calls on a 4-deep stack -> 5th call increments pc and sets stack_err, and stack contents are unchanged.
REQ-042 The bench SHALL cover: reset asserted asynchronously mid-cycle while HALTED with stack_err=1 -> pc=0, halted=0, stack_err=0 immediately, without waiting for a clock edge.
